// File: rtl/sha256_block_loader.sv
// ---------------------------------------------------------------------------
// sha256_block_loader
//
// Front end of the simplified SHA-256 datapath. On start it reads
// NUM_OF_WORDS consecutive 32-bit message words from a word-wide synchronous
// memory, packs them into a 16-word block (words past NUM_OF_WORDS are zero),
// hands the block to the hash core through a start/done handshake and pulses
// done once the core has finished with it.
//
// Ports
//   clk            in   1    single clock, also forwarded to the memory
//   reset_n        in   1    asynchronous active-low reset
//   start          in   1    begin a load (only looked at while idle)
//   message_addr   in   16   word address of message word 0, taken with start
//   mem_clk        out  1    memory clock (= clk)
//   mem_we         out  1    memory write enable, always 0
//   mem_addr       out  16   registered read address
//   mem_read_data  in   32   read data, valid one cycle after its address
//   block_words    out  512  packed block, word k at [32*k +: 32]
//   sha_start      out  1    one-cycle launch pulse to the core
//   sha_done       in   1    core idle flag
//   busy           out  1    high whenever the loader is not idle
//   done           out  1    one-cycle pulse when the core has consumed the block
// ---------------------------------------------------------------------------
module sha256_block_loader #(
    parameter int NUM_OF_WORDS = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [15:0]  message_addr,
    output logic         mem_clk,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    input  logic [31:0]  mem_read_data,
    output logic [511:0] block_words,
    output logic         sha_start,
    input  logic         sha_done,
    output logic         busy,
    output logic         done
);

    if (NUM_OF_WORDS < 1 || NUM_OF_WORDS > 16) begin : g_bad_num_of_words
        $error("sha256_block_loader: NUM_OF_WORDS must be in 1..16");
    end

    localparam logic [4:0] WORD_COUNT = 5'(NUM_OF_WORDS);
    localparam logic [4:0] LAST_IDX   = 5'(NUM_OF_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t      state_reg;
    logic [4:0]  issue_cnt_reg;   // addresses handed to the memory so far
    logic [4:0]  cap_idx_reg;     // next block word to be written
    logic        cap_valid_reg;   // mem_read_data carries a word this cycle
    logic [1:0]  guard_cnt_reg;   // cycles the core stayed idle after a launch

    assign mem_clk = clk;
    assign mem_we  = 1'b0;

    // The core is launched with a registered pulse. Whenever the loader
    // enters or sits in LAUNCH, sha_start is loaded with the current
    // sha_done, so the pulse is visible in the first LAUNCH cycle in which
    // the core was idle at the preceding edge. A LAUNCH cycle that carries
    // the pulse moves on to WAIT_BUSY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            mem_addr      <= 16'h0000;
            issue_cnt_reg <= 5'd0;
            cap_idx_reg   <= 5'd0;
            cap_valid_reg <= 1'b0;
            guard_cnt_reg <= 2'd0;
            sha_start     <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
        end else begin
            unique case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        mem_addr      <= message_addr;
                        issue_cnt_reg <= 5'd0;
                        cap_idx_reg   <= 5'd0;
                        cap_valid_reg <= 1'b0;
                        busy          <= 1'b1;
                        state_reg     <= S_READ;
                    end
                end

                S_READ: begin
                    // Address issue runs one cycle ahead of data capture.
                    if (issue_cnt_reg < WORD_COUNT) begin
                        mem_addr      <= mem_addr + 16'd1;
                        issue_cnt_reg <= issue_cnt_reg + 5'd1;
                        cap_valid_reg <= 1'b1;
                    end else begin
                        cap_valid_reg <= 1'b0;
                    end

                    if (cap_valid_reg) begin
                        cap_idx_reg <= cap_idx_reg + 5'd1;
                        if (cap_idx_reg == LAST_IDX) begin
                            cap_valid_reg <= 1'b0;
                            sha_start     <= sha_done;
                            state_reg     <= S_LAUNCH;
                        end
                    end
                end

                S_LAUNCH: begin
                    if (sha_start) begin
                        sha_start     <= 1'b0;
                        guard_cnt_reg <= 2'd0;
                        state_reg     <= S_WAIT_BUSY;
                    end else begin
                        sha_start <= sha_done;
                    end
                end

                S_WAIT_BUSY: begin
                    // A core that is still idle after four cycles never saw
                    // the pulse; go back and launch again.
                    if (!sha_done) begin
                        state_reg <= S_WAIT_DONE;
                    end else if (guard_cnt_reg == 2'd3) begin
                        guard_cnt_reg <= 2'd0;
                        sha_start     <= 1'b1;
                        state_reg     <= S_LAUNCH;
                    end else begin
                        guard_cnt_reg <= guard_cnt_reg + 2'd1;
                    end
                end

                S_WAIT_DONE: begin
                    if (sha_done) begin
                        done      <= 1'b1;
                        state_reg <= S_FINISH;
                    end
                end

                S_FINISH: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    sha_start <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // One register per block word. Words beyond NUM_OF_WORDS are constant
    // zero; the core applies the message padding itself. Captured words are
    // held until the next accepted start clears the block.
    for (genvar gi = 0; gi < 16; gi++) begin : g_word
        if (gi < NUM_OF_WORDS) begin : g_capture
            logic [31:0] word_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    word_reg <= 32'h0000_0000;
                end else if (state_reg == S_IDLE && start) begin
                    word_reg <= 32'h0000_0000;
                end else if (state_reg == S_READ && cap_valid_reg &&
                             cap_idx_reg == 5'(gi)) begin
                    word_reg <= mem_read_data;
                end
            end

            assign block_words[gi*32 +: 32] = word_reg;
        end else begin : g_zero
            assign block_words[gi*32 +: 32] = 32'h0000_0000;
        end
    end

endmodule
